// File: rtl/sram_like_resp.sv
// In-order SRAM-like bus responder with a word-addressed memory and a DEPTH-entry response FIFO.
// Optional macro SRAM_RESP_RAND_EN adds LFSR-driven addr_ok gating and latency jitter.
module sram_like_resp #(
    parameter int MEM_AW   = 10,
    parameter int DEPTH    = 2,
    parameter int DATA_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [3:0] LAT_M1 = 4'(DATA_LAT - 1);

    logic [31:0]       mem [2**MEM_AW];
    logic [31:0]       fifo_data [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_next;
    logic [3:0]        cnt;
    logic [3:0]        cnt_load;
    logic [MEM_AW-1:0] widx;
    logic              accept;
    logic              head_valid;
    logic              new_head;
    logic              unused_bits;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (DEPTH == 1) ? '0 : p + PW'(1);
    endfunction

`ifdef SRAM_RESP_RAND_EN
    logic [15:0] lfsr;
    logic [4:0]  load_sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign load_sum = {1'b0, LAT_M1} + {2'b00, lfsr[3:1]};
    assign cnt_load = (load_sum > 5'd15) ? 4'd15 : load_sum[3:0];
    assign addr_ok  = req & (count < CW'(DEPTH)) & ~reset & lfsr[0];
`else
    assign cnt_load = LAT_M1;
    assign addr_ok  = req & (count < CW'(DEPTH)) & ~reset;
`endif

    assign unused_bits = ^{size, addr[31:MEM_AW+2], addr[1:0]};

    assign widx       = addr[MEM_AW+1:2];
    assign accept     = addr_ok;
    assign head_valid = (count != '0);
    assign data_ok    = head_valid & (cnt == 4'd0);
    assign rdata      = data_ok ? fifo_data[rd_ptr] : 32'd0;
    assign count_next = count + CW'(accept) - CW'(data_ok);
    // A fresh head restarts the latency count, whether it arrived into an empty queue or was exposed by a dequeue.
    assign new_head   = (accept & ~head_valid) | (data_ok & (count_next != '0));

    always_ff @(posedge clk) begin
        if (accept && wr) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[widx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Read data is captured from the pre-write memory value at acceptance, so later writes never alter it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            cnt    <= 4'd0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data[i] <= 32'd0;
            end
        end else begin
            if (accept) begin
                fifo_data[wr_ptr] <= wr ? 32'd0 : mem[widx];
                wr_ptr            <= ptr_inc(wr_ptr);
            end
            if (data_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count_next;
            if (new_head) begin
                cnt <= cnt_load;
            end else if (head_valid && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

endmodule
